cpu_bus_sched: RTL and testbench
================================

Name: cpu_bus_sched

Overview:
- Generates the CPU phase clock (`phi0`) and `rdy` for the p6502 wrapper.
- Time-multiplexes the shared program/work RAM bus between the CPU and a video/DMA fetch requester.
- Each CPU cycle is split into a video slot (`phi0` low) and a CPU slot (`phi0` high).
- Long video requests may steal a whole CPU read cycle by holding `rdy` low, with bounded starvation.

Parameters:
- DIV, 4, clk cycles per `phi0` half-phase (≥2); CPU cycle length = 2*DIV clk.
- STALL_MAX, 2, maximum consecutive CPU cycles that may be stolen by long video requests.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_phi0  out  1  CPU phase clock to p6502 `phi0`
- cpu_rdy  out  1  CPU ready; low = current CPU cycle stolen
- cpu_a  in  16  CPU address
- cpu_rw_n  in  1  CPU read(1)/write(0)
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  registered read data to CPU
- vid_req  in  1  video fetch request, level, held until vid_ack
- vid_long  in  1  qualifies vid_req as full-cycle (stealing) request
- vid_addr  in  16  video fetch address, stable while vid_req
- vid_data  out  8  registered fetch data
- vid_ack  out  1  one-clk pulse, vid_data valid
- mem_a  out  16  shared RAM address
- mem_we  out  1  shared RAM write strobe
- mem_wdata  out  8  shared RAM write data
- mem_rdata  in  8  shared RAM read data, valid one clk after mem_a

Behaviour:
- Reset (async): `cnt`=0, `cpu_phi0`=0, `cpu_rdy`=1, `cpu_din`=0, `vid_data`=0, `vid_ack`=0, `mem_we`=0, `mem_a`=0, `mem_wdata`=0, `stall_cnt`=0, owner=NONE.
- `cnt` runs 0..2*DIV-1 and wraps. `cpu_phi0` is registered: high for cnt in DIV..2*DIV-1, low otherwise.
- Owner FSM states: NONE, VID_SHORT, VID_LONG, CPU. All decisions are made on registered state. `mem_a`, `mem_wdata` and `mem_we` are registered outputs.
- At cnt=0:
  - vid_req=1 and vid_long=0 → VID_SHORT.
  - vid_req=1, vid_long=1 and stall_cnt<STALL_MAX → VID_LONG.
  - vid_req=1, vid_long=1 and stall_cnt=STALL_MAX → VID_SHORT (request served as a short fetch, not acked as long).
  - No vid_req → NONE.
  - In every case, `mem_a` is set to `vid_addr`, or held if NONE.
- VID_SHORT: `vid_data` captures `mem_rdata` at cnt=DIV-1. `vid_ack`=1 at cnt=DIV for one clk. At cnt=DIV, owner becomes CPU.
- At cnt=DIV-1, `cpu_rdy` for the coming CPU slot is decided:
  - `cpu_rdy`=0 iff owner=VID_LONG and cpu_rw_n=1.
  - If owner=VID_LONG and cpu_rw_n=0 (6502 ignores RDY on writes), the long request is demoted to short. Data capture and ack follow VID_SHORT timing, and stall_cnt is not incremented.
- VID_LONG with cpu_rdy=0: video keeps the bus for the whole cycle.
  - `vid_data` captures at cnt=2*DIV-1.
  - `vid_ack` pulses at the next cnt=0.
  - `stall_cnt`+=1, saturating at STALL_MAX.
  - `cpu_din` is not updated.
- CPU slot (owner=CPU):
  - `mem_a`=cpu_a at cnt=DIV.
  - Write (cpu_rw_n=0): `mem_wdata`=cpu_dout. `mem_we`=1 for exactly one clk at cnt=2*DIV-2.
  - Read: `cpu_din` captures `mem_rdata` at cnt=2*DIV-1.
  - `stall_cnt` clears to 0 at the end of any unstolen CPU cycle.
- `cpu_rdy` returns to 1 at cnt=0 following a stolen cycle.
- vid_req deasserted before ack (protocol violation): grant still completes and acks. Never more than one outstanding ack.
- Simultaneous vid_ack and new vid_req at cnt=0 (long case): the new request is evaluated in the same clk. Back-to-back long fetches are allowed up to STALL_MAX.
- Reset mid-cycle: all state returns to reset values immediately. Any in-flight `mem_we` is dropped. `cpu_phi0` restarts low.

Test Plan:
- DIV=4, no vid_req, CPU read cpu_a=0x0123, mem_rdata=0x5A → `cpu_phi0` period 8 clk, 50% duty; mem_a=0x0123 from cnt=4; cpu_din=0x5A after cnt=7; cpu_rdy stays 1.
- CPU write cpu_a=0x0400, cpu_dout=0xC3 → mem_we high exactly one clk at cnt=6 with mem_a=0x0400, mem_wdata=0xC3; no other mem_we.
- Short vid_req vid_addr=0x2000, mem_rdata=0x11 → mem_a=0x2000 during cnt 0..3; vid_data=0x11; vid_ack one clk at cnt=4; CPU slot unaffected.
- Long vid_req held continuously, CPU reading, STALL_MAX=2 → cpu_rdy low for cycles 1 and 2, acks at the cnt=0 ending each; cycle 3 served short with cpu_rdy=1; stall_cnt clears, then stealing resumes.
- Long vid_req during a CPU write cycle → cpu_rdy stays 1; vid_ack at cnt=4; write completes with mem_we at cnt=6.
- Assert reset at cnt=5 during a write → immediate: mem_we=0, cpu_phi0=0, cpu_rdy=1, vid_ack=0; after release, cnt restarts at 0.

Source files
------------

// File: rtl/cpu_bus_sched.sv
// cpu_bus_sched: phi0/rdy generation and shared RAM bus arbitration between
// the 6502 core and a video/DMA fetch requester. Each CPU cycle is 2*DIV clk:
// a video slot (phi0 low) followed by a CPU slot (phi0 high). A long video
// request may steal a whole CPU read cycle, but at most STALL_MAX in a row.
// "At cnt=N" below means the registered value is visible while cnt_q==N.
module cpu_bus_sched #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned STALL_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_phi0,
  output logic        cpu_rdy,
  input  logic [15:0] cpu_a,
  input  logic        cpu_rw_n,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        vid_req,
  input  logic        vid_long,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_ack,
  output logic [15:0] mem_a,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned CYC     = 2 * DIV;
  localparam int unsigned CNT_W   = $clog2(CYC);
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

  // Counter values on which the next-state logic acts (state entering cnt+1).
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_RDY = CNT_W'(DIV - 2);
  localparam logic [CNT_W-1:0] CNT_PRE_CPU = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_WE  = CNT_W'(CYC - 3);
  localparam logic [CNT_W-1:0] CNT_PRE_END = CNT_W'(CYC - 2);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID_SHORT,
    OWN_VID_LONG,
    OWN_CPU
  } owner_e;

  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               phi0_q, phi0_d;
  logic               rdy_q, rdy_d;
  logic [7:0]         din_q, din_d;
  logic [7:0]         vdata_q, vdata_d;
  logic               ack_q, ack_d;
  logic [15:0]        a_q, a_d;
  logic               we_q, we_d;
  logic [7:0]         wdata_q, wdata_d;

  // State register: everything returns to reset values immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      stall_q <= '0;
      phi0_q  <= 1'b0;
      rdy_q   <= 1'b1;
      din_q   <= '0;
      vdata_q <= '0;
      ack_q   <= 1'b0;
      a_q     <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      phi0_q  <= phi0_d;
      rdy_q   <= rdy_d;
      din_q   <= din_d;
      vdata_q <= vdata_d;
      ack_q   <= ack_d;
      a_q     <= a_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state: phase counter, bus owner, stall accounting and bus outputs.
  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    phi0_d  = (cnt_d >= CNT_W'(DIV));
    owner_d = owner_q;
    stall_d = stall_q;
    rdy_d   = rdy_q;
    din_d   = din_q;
    vdata_d = vdata_q;
    ack_d   = 1'b0;
    a_d     = a_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;

    // Cycle boundary: finish a stolen cycle and grant the video slot.
    if (cnt_q == CNT_LAST) begin
      rdy_d = 1'b1;
      if (owner_q == OWN_VID_LONG) ack_d = 1'b1;
      if (vid_req) begin
        a_d = vid_addr;
        if (vid_long && (stall_q < STALL_LIM)) owner_d = OWN_VID_LONG;
        else                                   owner_d = OWN_VID_SHORT;
      end else begin
        owner_d = OWN_NONE;
      end
    end

    // End of video slot: decide rdy; writes cannot be stalled so demote.
    if (cnt_q == CNT_PRE_RDY) begin
      if (owner_q == OWN_VID_LONG) begin
        if (cpu_rw_n) begin
          rdy_d = 1'b0;
          if (stall_q != STALL_LIM) stall_d = stall_q + STALL_W'(1);
        end else begin
          owner_d = OWN_VID_SHORT;
          vdata_d = mem_rdata;
        end
      end else if (owner_q == OWN_VID_SHORT) begin
        vdata_d = mem_rdata;
      end
    end

    // Start of CPU slot, unless the whole cycle has been stolen.
    if (cnt_q == CNT_PRE_CPU && owner_q != OWN_VID_LONG) begin
      if (owner_q == OWN_VID_SHORT) ack_d = 1'b1;
      owner_d = OWN_CPU;
      a_d     = cpu_a;
      wdata_d = cpu_dout;
    end

    // Single-clk write strobe late in the CPU slot.
    if (cnt_q == CNT_PRE_WE && owner_d == OWN_CPU && !cpu_rw_n) we_d = 1'b1;

    // Last clk of the cycle: read capture for whoever owns the bus.
    if (cnt_q == CNT_PRE_END) begin
      if (owner_q == OWN_CPU && cpu_rw_n) din_d   = mem_rdata;
      if (owner_q == OWN_VID_LONG)        vdata_d = mem_rdata;
      if (rdy_q)                          stall_d = '0;
    end
  end

  assign cpu_phi0  = phi0_q;
  assign cpu_rdy   = rdy_q;
  assign cpu_din   = din_q;
  assign vid_data  = vdata_q;
  assign vid_ack   = ack_q;
  assign mem_a     = a_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_cpu_bus_sched.sv
// Directed bench for cpu_bus_sched with DIV=4, STALL_MAX=2.
module tb_cpu_bus_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_phi0, cpu_rdy;
  logic [15:0] cpu_a;
  logic        cpu_rw_n;
  logic [7:0]  cpu_dout, cpu_din;
  logic        vid_req, vid_long;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_ack;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int tcnt    = 0;
  int n_we    = 0;
  logic [15:0] last_wa = '0;
  logic [7:0]  last_wd = '0;

  cpu_bus_sched #(.DIV(4), .STALL_MAX(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_phi0(cpu_phi0), .cpu_rdy(cpu_rdy),
    .cpu_a(cpu_a), .cpu_rw_n(cpu_rw_n), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .vid_req(vid_req), .vid_long(vid_long), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_ack(vid_ack),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Bench-side phase counter: expected position within the CPU cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) tcnt <= 0;
    else       tcnt <= (tcnt == 7) ? 0 : tcnt + 1;
  end

  function automatic logic [7:0] rd(input logic [15:0] a);
    case (a)
      16'h0123: rd = 8'h5A;
      16'h0124: rd = 8'h77;
      16'h0125: rd = 8'h44;
      16'h2000: rd = 8'h11;
      16'h3000: rd = 8'h22;
      16'h3100: rd = 8'h55;
      default:  rd = a[7:0] ^ a[15:8];
    endcase
  endfunction

  // RAM model: read data one clk after address; write log for checking.
  always @(posedge clk) begin
    mem_rdata <= rd(mem_a);
    if (mem_we) begin
      n_we    <= n_we + 1;
      last_wa <= mem_a;
      last_wd <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic goto(input int c);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tcnt == c) return;
    end
    check("goto_timeout", 32'(tcnt), 32'(c));
  endtask

  initial begin
    reset = 1'b1; cpu_a = 16'h0123; cpu_rw_n = 1'b1; cpu_dout = 8'h00;
    vid_req = 1'b0; vid_long = 1'b0; vid_addr = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_phi0",  32'(cpu_phi0), 32'h0);
    check("rst_rdy",   32'(cpu_rdy), 32'h1);
    check("rst_din",   32'(cpu_din), 32'h0);
    check("rst_vdata", 32'(vid_data), 32'h0);
    check("rst_ack",   32'(vid_ack), 32'h0);
    check("rst_we",    32'(mem_we), 32'h0);
    check("rst_mema",  32'(mem_a), 32'h0);
    check("rst_wdata", 32'(mem_wdata), 32'h0);
    reset = 1'b0;

    // Idle video, CPU read of 0x0123.
    for (int c = 0; c < 8; c++) begin
      if (c != 0) goto(c);
      check("rd_phi0", 32'(cpu_phi0), 32'(c >= 4));
      check("rd_rdy", 32'(cpu_rdy), 32'h1);
      if (c == 4) check("rd_mema", 32'(mem_a), 32'h0123);
      if (c == 7) check("rd_din", 32'(cpu_din), 32'h5A);
    end

    // CPU write of 0xC3 to 0x0400.
    cpu_rw_n = 1'b0; cpu_a = 16'h0400; cpu_dout = 8'hC3;
    for (int c = 0; c < 8; c++) begin
      goto(c);
      check("wr_we", 32'(mem_we), 32'(c == 6));
      if (c == 6) begin
        check("wr_mema", 32'(mem_a), 32'h0400);
        check("wr_wdata", 32'(mem_wdata), 32'hC3);
      end
    end

    // Short video fetch from 0x2000, CPU reads 0x0124.
    cpu_rw_n = 1'b1; cpu_a = 16'h0124;
    vid_req = 1'b1; vid_long = 1'b0; vid_addr = 16'h2000;
    for (int c = 0; c < 8; c++) begin
      goto(c);
      check("sv_ack", 32'(vid_ack), 32'(c == 4));
      check("sv_rdy", 32'(cpu_rdy), 32'h1);
      if (c < 4) check("sv_mema", 32'(mem_a), 32'h2000);
      if (c == 4) begin
        check("sv_vdata", 32'(vid_data), 32'h11);
        check("sv_mema_cpu", 32'(mem_a), 32'h0124);
        vid_req = 1'b0;
      end
      if (c == 7) check("sv_din", 32'(cpu_din), 32'h77);
    end

    // Long video fetches held continuously while CPU reads 0x0125.
    cpu_a = 16'h0125; vid_req = 1'b1; vid_long = 1'b1; vid_addr = 16'h3000;
    for (int k = 1; k <= 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        goto(c);
        if (c == 0) begin
          check("lg_ack0", 32'(vid_ack), 32'(k == 2 || k == 3));
          check("lg_rdy0", 32'(cpu_rdy), 32'h1);
        end
        if (c == 4) check("lg_ack4", 32'(vid_ack), 32'(k == 3));
        if (c == 5) begin
          check("lg_rdy5", 32'(cpu_rdy), 32'(k == 3));
          check("lg_mema", 32'(mem_a), (k == 3) ? 32'h0125 : 32'h3000);
        end
        if (c == 7) begin
          check("lg_din", 32'(cpu_din), (k < 3) ? 32'h77 : 32'h44);
          check("lg_vdata", 32'(vid_data), 32'h22);
          if (k == 4) vid_req = 1'b0;
        end
      end
    end
    goto(0);
    check("lg_ack_last", 32'(vid_ack), 32'h1);

    // Long request during a CPU write is demoted to short.
    goto(7);
    vid_req = 1'b1; vid_long = 1'b1; vid_addr = 16'h3100;
    cpu_rw_n = 1'b0; cpu_a = 16'h0500; cpu_dout = 8'h3C;
    for (int c = 0; c < 8; c++) begin
      goto(c);
      check("lw_rdy", 32'(cpu_rdy), 32'h1);
      check("lw_ack", 32'(vid_ack), 32'(c == 4));
      check("lw_we", 32'(mem_we), 32'(c == 6));
      if (c == 4) begin
        check("lw_vdata", 32'(vid_data), 32'h55);
        vid_req = 1'b0;
      end
      if (c == 6) begin
        check("lw_mema", 32'(mem_a), 32'h0500);
        check("lw_wdata", 32'(mem_wdata), 32'h3C);
      end
    end

    // Reset at cnt=5 of a write cycle.
    cpu_a = 16'h0600; cpu_dout = 8'hA5;
    goto(5);
    check("pr_phi0", 32'(cpu_phi0), 32'h1);
    reset = 1'b1;
    #1;
    check("mr_phi0",  32'(cpu_phi0), 32'h0);
    check("mr_rdy",   32'(cpu_rdy), 32'h1);
    check("mr_ack",   32'(vid_ack), 32'h0);
    check("mr_we",    32'(mem_we), 32'h0);
    check("mr_mema",  32'(mem_a), 32'h0);
    check("mr_wdata", 32'(mem_wdata), 32'h0);
    check("mr_din",   32'(cpu_din), 32'h0);
    check("mr_vdata", 32'(vid_data), 32'h0);
    repeat (2) @(negedge clk);
    check("mr_we_hold", 32'(mem_we), 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) goto(c);
      check("ar_phi0", 32'(cpu_phi0), 32'(c >= 4));
      check("ar_we", 32'(mem_we), 32'(c == 6));
      if (c == 6) check("ar_mema", 32'(mem_a), 32'h0600);
    end
    goto(1);
    check("we_count", 32'(n_we), 32'd3);
    check("we_last_a", 32'(last_wa), 32'h0600);
    check("we_last_d", 32'(last_wd), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
